// File: rtl/wb_pwm_decoder.sv
// wb_pwm_decoder: six-channel RC PWM high-time decoder (µs) behind a Wishbone classic slave.
// Define PWM_DEC_GLITCH_FILTER_EN to add a per-channel GLITCH_CYCLES stability filter.
module wb_pwm_decoder #(
    parameter int CLK_FREQ_HZ   = 72000000,
    parameter int NUM_CH        = 6,
    parameter int MIN_US        = 800,
    parameter int MAX_US        = 2200,
    parameter int TIMEOUT_US    = 50000,
    parameter int GLITCH_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    input  logic [NUM_CH-1:0] i_pwm,
    output logic [NUM_CH-1:0] o_valid
);
    localparam int DIV = CLK_FREQ_HZ / 1000000;
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int TW = $clog2(TIMEOUT_US + 1);
    localparam logic [15:0] W_MIN = 16'(MIN_US);
    localparam logic [15:0] W_MAX = 16'(MAX_US);
    localparam logic [15:0] W_SAT = 16'(MAX_US + 1);
    localparam logic [TW-1:0] T_END = TW'(TIMEOUT_US);

    typedef enum logic {S_IDLE, S_HIGH} state_t;

    logic [PW-1:0]     r_pre;
    logic              w_tick;
    logic [NUM_CH-1:0] w_valid;
    logic [15:0]       w_width [NUM_CH];
    logic [31:0]       w_rd_ch [8];
    logic [31:0]       w_rdata;
    logic [31:0]       r_dat;
    logic              r_ack;
    logic              w_req;
    logic              w_unused;

    assign w_tick = r_pre == PW'(DIV - 1);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_pre <= '0;
        else       r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic          r_s1, r_s2, r_prev, w_lvl, w_rise, w_fall;
        logic          r_armed, r_v;
        logic [15:0]   r_wcnt, r_w;
        logic [TW-1:0] r_to;
        state_t        r_state, w_state_nxt;

        // Sync chain keeps tracking through reset so a pulse already high at release is not seen as a rise.
        always_ff @(posedge i_clk) begin
            r_s1   <= i_pwm[c];
            r_s2   <= r_s1;
            r_prev <= w_lvl;
        end

`ifdef PWM_DEC_GLITCH_FILTER_EN
        localparam int GW = $clog2(GLITCH_CYCLES + 1);
        logic          r_filt;
        logic [GW-1:0] r_gcnt;
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_filt <= r_s2;
                r_gcnt <= '0;
            end else if (r_s2 == r_filt) begin
                r_gcnt <= '0;
            end else if (r_gcnt == GW'(GLITCH_CYCLES - 1)) begin
                r_filt <= r_s2;
                r_gcnt <= '0;
            end else begin
                r_gcnt <= r_gcnt + 1'b1;
            end
        end
        assign w_lvl = r_filt;
`else
        assign w_lvl = r_s2;
`endif

        assign w_rise = w_lvl & ~r_prev;
        assign w_fall = ~w_lvl & r_prev;

        always_comb begin
            w_state_nxt = r_state;
            if (r_state == S_IDLE && w_rise)      w_state_nxt = S_HIGH;
            else if (r_state == S_HIGH && w_fall) w_state_nxt = S_IDLE;
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) r_state <= S_IDLE;
            else       r_state <= w_state_nxt;
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_wcnt  <= '0;
                r_to    <= '0;
                r_armed <= 1'b0;
                r_w     <= '0;
                r_v     <= 1'b0;
            end else begin
                if (w_rise)                       r_to <= '0;
                else if (w_tick && r_to != T_END) r_to <= r_to + 1'b1;
                if (r_state == S_IDLE && w_rise) begin
                    r_wcnt  <= '0;
                    r_armed <= 1'b1;
                end else if (r_state == S_HIGH) begin
                    if (w_fall) begin
                        r_armed <= 1'b0;
                        if (r_armed && r_wcnt >= W_MIN && r_wcnt <= W_MAX) begin
                            r_w <= r_wcnt;
                            r_v <= 1'b1;
                        end
                    end else if (w_tick && r_wcnt != W_SAT) begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                // A rise on the same cycle as the timeout wins: the channel stays valid.
                if (!w_rise && r_to == T_END) begin
                    r_w <= '0;
                    r_v <= 1'b0;
                end
            end
        end

        assign w_valid[c] = r_v;
        assign w_width[c] = r_w;
    end

    for (genvar c = 0; c < 8; c++) begin : g_rd
        if (c < NUM_CH) begin : g_map
            assign w_rd_ch[c] = {w_valid[c], 15'b0, w_width[c]};
        end else begin : g_nomap
            assign w_rd_ch[c] = '0;
        end
    end

    assign w_rdata = wb_adr_i[4:2] == 3'd7 ? {24'b0, 8'(w_valid)} : w_rd_ch[wb_adr_i[4:2]];
    assign w_req   = wb_cyc_i & wb_stb_i & ~r_ack;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            if (w_req) r_dat <= w_rdata;
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign o_valid  = w_valid;
    assign w_unused = ^{wb_dat_i, wb_sel_i, wb_we_i, wb_adr_i[7:5], wb_adr_i[1:0]};
endmodule

// File: tb/tb_wb_pwm_decoder.sv
// tb_wb_pwm_decoder: directed table-driven bench for wb_pwm_decoder at a 2 MHz clock and 5 ms timeout.
module tb_wb_pwm_decoder;
    localparam int NCH = 6;
    localparam int DIV = 2;
    localparam int TO  = 5000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     adr = '0;
    logic [31:0]    dat_i = '0;
    logic [3:0]     sel = '0;
    logic           we = 1'b0;
    logic           stb = 1'b0;
    logic           cyc = 1'b0;
    logic [31:0]    dat_o;
    logic           ack;
    logic [NCH-1:0] pwm = '0;
    logic [NCH-1:0] valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_pwm_decoder #(
        .CLK_FREQ_HZ(2000000),
        .NUM_CH(NCH),
        .MIN_US(800),
        .MAX_US(2200),
        .TIMEOUT_US(TO),
        .GLITCH_CYCLES(4)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel), .wb_we_i(we),
        .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_dat_o(dat_o), .wb_ack_o(ack),
        .i_pwm(pwm), .o_valid(valid)
    );

    typedef struct {
        int          ch;
        int          us;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    function automatic logic [31:0] rdw(input int w);
        return {1'b1, 15'b0, 16'(w)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] lo, input logic [31:0] hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h..0x%08h", name, act, lo, hi);
        end
    endtask

    task automatic wait_us(input int us);
        repeat (us * DIV) @(posedge clk);
    endtask

    task automatic pulse(input int ch, input int us);
        @(negedge clk);
        pwm[ch] = 1'b1;
        wait_us(us);
        @(negedge clk);
        pwm[ch] = 1'b0;
    endtask

    task automatic wb(input logic w, input logic [7:0] a, output logic [31:0] d, output int lat);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = 32'hDEAD_BEEF; sel = 4'hF;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ack && lat < 8);
        d = dat_o;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] lo, input logic [31:0] hi);
        logic [31:0] d;
        int          lat;
        wb(1'b0, a, d, lat);
        chk({name, " ack latency"}, 32'(lat), 32'd1, 32'd1);
        chk({name, " data"}, d, lo, hi);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, want finish before 1500000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tv[7];
        logic [31:0] d;
        int          lat;
        tv[0] = '{0, 1500, rdw(1499), rdw(1501)};
        tv[1] = '{1, 1000, rdw(999),  rdw(1001)};
        tv[2] = '{1, 799,  rdw(999),  rdw(1001)};
        tv[3] = '{1, 2300, rdw(999),  rdw(1001)};
        tv[4] = '{2, 1200, rdw(1199), rdw(1201)};
        tv[5] = '{1, 810,  rdw(809),  rdw(811)};
        tv[6] = '{1, 2190, rdw(2189), rdw(2191)};

        repeat (5) @(posedge clk);
        #1;
        chk("reset ack", 32'(ack), 0, 0);
        chk("reset dat", dat_o, 0, 0);
        chk("reset valid", 32'(valid), 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            pulse(tv[i].ch, tv[i].us);
            wait_us(20);
            rd_chk($sformatf("vec%0d ch%0d %0dus", i, tv[i].ch, tv[i].us), 8'(tv[i].ch * 4), tv[i].lo, tv[i].hi);
            chk($sformatf("vec%0d o_valid", i), 32'(valid[tv[i].ch]), 1, 1);
        end

        pulse(2, 1200);
        wait_us(TO - 1200 - 20);
        chk("ch2 valid before timeout", 32'(valid[2]), 1, 1);
        wait_us(40);
        chk("ch2 valid after timeout", 32'(valid[2]), 0, 0);
        rd_chk("ch2 after timeout", 8'h08, 0, 0);

        @(negedge clk);
        pwm[3] = 1'b1;
        wait_us(100);
        do_reset(5);
        #1;
        chk("mid-pulse reset valid", 32'(valid), 0, 0);
        wait_us(500);
        @(negedge clk);
        pwm[3] = 1'b0;
        wait_us(20);
        rd_chk("ch3 fall after reset", 8'h0C, 0, 0);
        chk("ch3 valid after reset", 32'(valid[3]), 0, 0);
        pulse(3, 1800);
        wait_us(20);
        rd_chk("ch3 1800us", 8'h0C, rdw(1799), rdw(1801));

        do_reset(3);
        pulse(0, 1000);
        pulse(5, 1500);
        wait_us(20);
        rd_chk("status ch0+ch5", 8'h1C, 32'h21, 32'h21);
        wb(1'b1, 8'h00, d, lat);
        chk("write ack latency", 32'(lat), 1, 1);
        rd_chk("ch0 after write", 8'h00, rdw(999), rdw(1001));
        rd_chk("unmapped 0x18", 8'h18, 0, 0);

        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = 8'h1C;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("back-to-back ack %0d", k), 32'(ack), 32'(k % 2 == 0), 32'(k % 2 == 0));
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;

        pulse(4, 1000);
        wait_us(20);
        chk("ch4 valid before glitch", 32'(valid[4]), 1, 1);
        wait_us(3000);
        @(negedge clk);
        pwm[4] = 1'b1;
        repeat (2) @(negedge clk);
        pwm[4] = 1'b0;
        wait_us(2000);
`ifdef PWM_DEC_GLITCH_FILTER_EN
        chk("ch4 glitch filtered valid", 32'(valid[4]), 0, 0);
        rd_chk("ch4 glitch filtered", 8'h10, 0, 0);
`else
        chk("ch4 glitch restarts timeout", 32'(valid[4]), 1, 1);
        rd_chk("ch4 glitch rejected", 8'h10, rdw(999), rdw(1001));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
